raw_bayer_demosaic_px: RTL

Parametrised raw Bayer to RGB/grayscale converter for the D8M camera path. It includes its own X/Y pixel counters and a one-line buffer, and forms a 2x2 window that can be configured for any CFA phase. Output is RGB, luma-replicated gray, or a colour-bar test pattern, with a fixed 3-cycle pipeline latency. It sits between the frame-buffer read port and the VGA output mux.

---
 rtl/raw_bayer_demosaic_px_pkg.sv | 18 +
 rtl/raw_bayer_demosaic_px_if.sv | 30 +++
 rtl/raw_bayer_demosaic_px_bayer_line_ram.sv | 23 ++
 rtl/raw_bayer_demosaic_px.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/raw_bayer_demosaic_px_pkg.sv
// rtl/raw_bayer_demosaic_px_pkg.sv - shared output modes and luma coefficients
// Purpose: constants shared by the Bayer demosaic top and its testbench.
package raw_bayer_demosaic_px_pkg;

  typedef enum logic [1:0] {
    MODE_RGB  = 2'd0,
    MODE_GRAY = 2'd1,
    MODE_BARS = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  // BT.601-style luma weights scaled by 2^LUMA_SHIFT; they sum to 256
  localparam int LUMA_R     = 77;
  localparam int LUMA_G     = 150;
  localparam int LUMA_B     = 29;
  localparam int LUMA_SHIFT = 8;

endpackage

// File: rtl/raw_bayer_demosaic_px_if.sv
// rtl/raw_bayer_demosaic_px_if.sv - raw pixel in / RGB pixel out bundle
// Purpose: groups the camera-side input strobe/data and the VGA-side outputs.
// Ports (master = pixel source/sink, slave = demosaic core):
//   iDATA  raw pixel, iVALID pixel strobe, iVS active-low frame sync, iMODE output mode
//   oRed/oGreen/oBlue/oGray output channels, oVALID delayed strobe, oDE in-window flag
interface raw_bayer_demosaic_px_if #(
  parameter int DATA_W = 10,
  parameter int OUT_W  = 8
);
  logic [DATA_W-1:0] iDATA;
  logic              iVALID;
  logic              iVS;
  logic [1:0]        iMODE;
  logic [OUT_W-1:0]  oRed;
  logic [OUT_W-1:0]  oGreen;
  logic [OUT_W-1:0]  oBlue;
  logic [OUT_W-1:0]  oGray;
  logic              oVALID;
  logic              oDE;

  modport master (
    output iDATA, iVALID, iVS, iMODE,
    input  oRed, oGreen, oBlue, oGray, oVALID, oDE
  );

  modport slave (
    input  iDATA, iVALID, iVS, iMODE,
    output oRed, oGreen, oBlue, oGray, oVALID, oDE
  );
endinterface

// File: rtl/raw_bayer_demosaic_px_bayer_line_ram.sv
// rtl/raw_bayer_demosaic_px_bayer_line_ram.sv - one-line buffer for the Bayer window
// Purpose: simple dual-port RAM, registered read, read-before-write on address collision.
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port (rdata valid one cycle later).
module bayer_line_ram #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 640,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset so the array maps onto block RAM
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end
endmodule

// File: rtl/raw_bayer_demosaic_px.sv
// rtl/raw_bayer_demosaic_px.sv - raw Bayer to RGB/gray/test-bar converter, 3-cycle pipeline
// Purpose: counts X/Y, buffers one line, forms a 2x2 CFA window, demosaics and muxes outputs.
// Ports: VGA_CLK clock; RESET_N async active-low reset; px slave side of the pixel bundle.
module raw_bayer_demosaic_px
  import raw_bayer_demosaic_px_pkg::*;
#(
  parameter int         DATA_W      = 10,
  parameter int         OUT_W       = 8,
  parameter int         LINE_MAX    = 640,
  parameter int         VAL_MIN     = 3,
  parameter int         VAL_MAX     = 637,
  parameter logic [1:0] BAYER_PHASE = 2'b00,
  parameter int         BAR_SHIFT   = 6
) (
  input logic VGA_CLK,
  input logic RESET_N,
  raw_bayer_demosaic_px_if.slave px
);
  localparam int XW = $clog2(LINE_MAX);
  localparam logic [XW-1:0] X_LAST = XW'(LINE_MAX - 1);
  localparam logic [XW-1:0] X_MIN  = XW'(VAL_MIN);
  localparam logic [XW-1:0] X_MAX  = XW'(VAL_MAX);

  // Counters and frame control
  logic [XW-1:0] x;
  logic [10:0]   y;
  mode_e         mode;
  logic          vld_d;
  logic          line_full;   // last buffer slot written; further pixels of this line dropped
  logic          wr_en;
  logic [DATA_W-1:0] ram_q;

  assign wr_en = px.iVALID && px.iVS && !line_full;

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      x         <= '0;
      y         <= '0;
      mode      <= MODE_RGB;
      vld_d     <= 1'b0;
      line_full <= 1'b0;
    end else begin
      vld_d <= px.iVALID && px.iVS;
      if (!px.iVS) begin
        x         <= '0;
        y         <= '0;
        mode      <= mode_e'(px.iMODE);
        line_full <= 1'b0;
      end else if (px.iVALID) begin
        if (x == X_LAST) line_full <= 1'b1;
        else             x <= x + XW'(1);
      end else if (vld_d) begin
        x         <= '0;
        y         <= y + 11'd1;
        line_full <= 1'b0;
      end
    end
  end

  bayer_line_ram #(.DATA_W(DATA_W), .DEPTH(LINE_MAX)) u_line_ram (
    .clk   (VGA_CLK),
    .we    (wr_en),
    .waddr (x),
    .wdata (px.iDATA),
    .raddr (x),
    .rdata (ram_q)
  );

  // Stage 1: window capture. ram_q is already aligned with this stage.
  logic              s1_v;
  logic [XW-1:0]     s1_x;
  logic [10:0]       s1_y;
  logic [DATA_W-1:0] p00, p10, p11, p01;

  // Mask the unreset RAM output until the first real pixel reaches stage 1
  assign p01 = s1_v ? ram_q : '0;

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_v <= 1'b0;
      s1_x <= '0;
      s1_y <= '0;
      p00  <= '0;
      p10  <= '0;
      p11  <= '0;
    end else begin
      s1_v <= px.iVALID;
      s1_x <= x;
      s1_y <= y;
      p11  <= px.iDATA;
      if (px.iVALID) begin
        // Left column is the previous pixel's column, none at the start of a line
        p00 <= (x == '0) ? '0 : p01;
        p10 <= (x == '0) ? '0 : p11;
      end
    end
  end

  // Stage 2: CFA mapping. Element (r,c) covers row Y-1+r, column X-1+c, so the red
  // element sits where parity XOR phase is 00 and blue is the diagonal opposite.
  logic              rr, cr;
  logic [DATA_W-1:0] win_px [2][2];
  logic [DATA_W-1:0] r_raw, b_raw, g_raw;
  logic [DATA_W:0]   g_sum;

  always_comb begin
    win_px[0][0] = p00;
    win_px[0][1] = p01;
    win_px[1][0] = p10;
    win_px[1][1] = p11;
    rr    = ~(s1_y[0] ^ BAYER_PHASE[1]);
    cr    = ~(s1_x[0] ^ BAYER_PHASE[0]);
    r_raw = win_px[rr][cr];
    b_raw = win_px[~rr][~cr];
    g_sum = {1'b0, win_px[rr][~cr]} + {1'b0, win_px[~rr][cr]};
    g_raw = DATA_W'(g_sum >> 1);
  end

  logic             s2_v, s2_win;
  logic [2:0]       s2_bar;
  logic [OUT_W-1:0] s2_r, s2_g, s2_b;

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s2_v   <= 1'b0;
      s2_win <= 1'b0;
      s2_bar <= '0;
      s2_r   <= '0;
      s2_g   <= '0;
      s2_b   <= '0;
    end else begin
      s2_v   <= s1_v;
      s2_win <= (s1_x > X_MIN) && (s1_x < X_MAX) && (s1_y != '0);
      s2_bar <= s1_x[BAR_SHIFT+2:BAR_SHIFT];
      s2_r   <= OUT_W'(r_raw >> (DATA_W - OUT_W));
      s2_g   <= OUT_W'(g_raw >> (DATA_W - OUT_W));
      s2_b   <= OUT_W'(b_raw >> (DATA_W - OUT_W));
    end
  end

  // Stage 3: luma and output mux
  logic [15:0]      luma_acc;
  logic [OUT_W-1:0] gray, n_r, n_g, n_b, n_gray;

  always_comb begin
    luma_acc = 16'(s2_r) * 16'(LUMA_R) + 16'(s2_g) * 16'(LUMA_G) + 16'(s2_b) * 16'(LUMA_B);
    gray     = OUT_W'(luma_acc >> LUMA_SHIFT);
    n_gray   = gray;
    case (mode)
      MODE_GRAY: begin
        n_r = gray;
        n_g = gray;
        n_b = gray;
      end
      MODE_BARS: begin
        n_r = {OUT_W{s2_bar[2]}};
        n_g = {OUT_W{s2_bar[1]}};
        n_b = {OUT_W{s2_bar[0]}};
      end
      default: begin
        n_r = s2_r;
        n_g = s2_g;
        n_b = s2_b;
      end
    endcase
    // Test bars are drawn across the full line; image modes blank outside the window
    if (mode != MODE_BARS && !s2_win) begin
      n_r    = '0;
      n_g    = '0;
      n_b    = '0;
      n_gray = '0;
    end
  end

  logic [OUT_W-1:0] o_r, o_g, o_b, o_gray;
  logic             o_v, o_de;

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      o_r    <= '0;
      o_g    <= '0;
      o_b    <= '0;
      o_gray <= '0;
      o_v    <= 1'b0;
      o_de   <= 1'b0;
    end else begin
      o_r    <= n_r;
      o_g    <= n_g;
      o_b    <= n_b;
      o_gray <= n_gray;
      o_v    <= s2_v;
      o_de   <= s2_win;
    end
  end

  assign px.oRed   = o_r;
  assign px.oGreen = o_g;
  assign px.oBlue  = o_b;
  assign px.oGray  = o_gray;
  assign px.oVALID = o_v;
  assign px.oDE    = o_de;
endmodule
